// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared types and helpers for the pmem burst arbiter.
//   - state_e       : arbiter FSM state encoding
//   - LINE_WIDTH,
//     BEAT_IDX_W,
//     OFFSET_W      : derived sizes for the default configuration
//                     (64-bit beats, 4-beat bursts)
//   - line_mask()   : address mask that clears the byte-in-line offset bits
package pmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_BEAT_WIDTH = 64;
    localparam int DEF_BURST_LEN  = 4;
    localparam int LINE_WIDTH     = DEF_BEAT_WIDTH * DEF_BURST_LEN;
    localparam int BEAT_IDX_W     = $clog2(DEF_BURST_LEN);
    localparam int OFFSET_W       = $clog2(LINE_WIDTH / 8);

    // Mask with the low offset_w bits cleared; callers truncate to their width.
    function automatic logic [63:0] line_mask(input int offset_w);
        line_mask = ~((64'd1 << offset_w) - 64'd1);
    endfunction

endpackage

// File: rtl/pmem_arb_checker.sv
// pmem_arb_checker: protocol checks on the client side of pmem_arbiter.
//   clk_i, rst_ni            : clock and synchronous active-low reset
//   req_read_i, req_write_i  : client request vectors
// A port asking for read and write at once is a client bug (write wins).
module pmem_arb_checker #(
    parameter int NUM_PORTS = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic [NUM_PORTS-1:0] req_read_i,
    input logic [NUM_PORTS-1:0] req_write_i
);

    a_no_rd_wr_same_port: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ((req_read_i & req_write_i) == '0)
    );

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks one requester out of N.
//   clk_i, rst_ni : clock and synchronous active-low reset (pointer only)
//   req_i         : request vector
//   update_i      : advance the priority pointer past the current winner
//   gnt_o, idx_o  : one-hot grant and its index (zero when nothing requests)
// PMEM_ARB_RR_EN defined  : round-robin, search starts after the last winner.
// PMEM_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic             update_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] start_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

`ifdef PMEM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    assign start_s = ptr_q;

    // Next pointer: the port after the one granted this cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i && (|req_i)) begin
            if (idx_o == IDX_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_o + 1'b1;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_s;

    assign start_s  = '0;
    assign unused_s = ^{clk_i, rst_ni, update_i};
`endif

    // Circular search from start_s; first requester found wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = IDX_W'((int'(start_s) + i) % N);
            if (!found_s && req_i[cand_s]) begin
                found_s       = 1'b1;
                idx_o         = cand_s;
                gnt_o[cand_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: arbitrates NUM_PORTS cache-line clients onto one burst
// memory port, serialising write lines and assembling read lines in
// BURST_LEN beats of BEAT_WIDTH bits.
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   req_read_i/req_write_i        : per-port line request, held until resp
//   req_addr_i/req_wdata_i        : per-port address and write line (packed)
//   req_resp_o                    : one-cycle completion pulse, one-hot
//   req_rdata_o                   : assembled read line, valid with resp
//   pmem_address_o                : line-aligned burst address
//   pmem_read_o/pmem_write_o      : burst strobes
//   pmem_wdata_o                  : current write beat
//   pmem_rdata_i/pmem_resp_i      : memory beat data and handshake
// Build option PMEM_ARB_RR_EN selects round-robin instead of fixed priority.
// Every output comes from registers; req_* never reaches pmem_* directly.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64,
    parameter int BURST_LEN  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_PORTS-1:0]                  req_read_i,
    input  logic [NUM_PORTS-1:0]                  req_write_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       req_addr_i,
    input  logic [NUM_PORTS*BEAT_WIDTH*BURST_LEN-1:0] req_wdata_i,
    output logic [NUM_PORTS-1:0]                  req_resp_o,
    output logic [BEAT_WIDTH*BURST_LEN-1:0]       req_rdata_o,
    output logic [ADDR_WIDTH-1:0]                 pmem_address_o,
    output logic                                  pmem_read_o,
    output logic                                  pmem_write_o,
    output logic [BEAT_WIDTH-1:0]                 pmem_wdata_o,
    input  logic [BEAT_WIDTH-1:0]                 pmem_rdata_i,
    input  logic                                  pmem_resp_i
);

    localparam int LINE_W = BEAT_WIDTH * BURST_LEN;
    localparam int BIDX_W = $clog2(BURST_LEN);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BURST_LEN - 1);

    if ((BURST_LEN < 2) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_bad_burst
        $error("pmem_arbiter: BURST_LEN must be a power of two >= 2");
    end

    state_e              state_q, state_d;
    logic [BIDX_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic [NUM_PORTS-1:0] pending_s;
    logic [NUM_PORTS-1:0] arb_gnt_s;
    logic [IDX_W-1:0]     arb_idx_s;
    logic                 arb_update_s;
    logic                 wr_sel_s;
    logic [ADDR_WIDTH-1:0] mask_s;

    assign pending_s = req_read_i | req_write_i;
    assign wr_sel_s  = |(arb_gnt_s & req_write_i);
    assign mask_s    = ADDR_WIDTH'(line_mask(OFF_W));

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (pending_s),
        .update_i (arb_update_s),
        .gnt_o    (arb_gnt_s),
        .idx_o    (arb_idx_s)
    );

    pmem_arb_checker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_read_i  (req_read_i),
        .req_write_i (req_write_i)
    );

    // Next-state logic. line_q doubles as write-line buffer and read
    // assembly buffer, so the burst never looks at client inputs after grant.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        line_d       = line_q;
        arb_update_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_s) begin
                    arb_update_s = 1'b1;
                    grant_d      = arb_idx_s;
                    beat_d       = '0;
                    addr_d       = req_addr_i[arb_idx_s*ADDR_WIDTH +: ADDR_WIDTH] & mask_s;
                    if (wr_sel_s) begin
                        line_d  = req_wdata_i[arb_idx_s*LINE_W +: LINE_W];
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (pmem_resp_i) begin
                    line_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = pmem_rdata_i;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (pmem_resp_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    // Completion pulse for the granted port while in DONE.
    always_comb begin
        req_resp_o = '0;
        if (state_q == ST_DONE) begin
            req_resp_o[grant_q] = 1'b1;
        end else begin
            req_resp_o = '0;
        end
    end

    assign pmem_read_o    = (state_q == ST_READ);
    assign pmem_write_o   = (state_q == ST_WRITE);
    assign pmem_address_o = addr_q;
    assign pmem_wdata_o   = line_q[beat_q*BEAT_WIDTH +: BEAT_WIDTH];
    assign req_rdata_o    = line_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed, table-driven bench for pmem_arbiter.
// Instance A: default config (2 ports, 64-bit beats, 4-beat bursts).
// Instance B: 3 ports, 32-bit beats, 8-beat bursts.
// Each instance talks to a small burst-memory model with configurable stall.
module tb_pmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A ----------------
    logic [1:0]   req_read_a, req_write_a, req_resp_a;
    logic [63:0]  req_addr_a;
    logic [511:0] req_wdata_a;
    logic [255:0] req_rdata_a;
    logic [31:0]  pmem_address_a;
    logic         pmem_read_a, pmem_write_a;
    logic [63:0]  pmem_wdata_a;
    logic [63:0]  prdata_a = 64'd0;
    logic         presp_a  = 1'b0;

    pmem_arbiter dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_read_i     (req_read_a),
        .req_write_i    (req_write_a),
        .req_addr_i     (req_addr_a),
        .req_wdata_i    (req_wdata_a),
        .req_resp_o     (req_resp_a),
        .req_rdata_o    (req_rdata_a),
        .pmem_address_o (pmem_address_a),
        .pmem_read_o    (pmem_read_a),
        .pmem_write_o   (pmem_write_a),
        .pmem_wdata_o   (pmem_wdata_a),
        .pmem_rdata_i   (prdata_a),
        .pmem_resp_i    (presp_a)
    );

    // ---------------- instance B ----------------
    logic [2:0]   req_read_b, req_write_b, req_resp_b;
    logic [95:0]  req_addr_b;
    logic [767:0] req_wdata_b;
    logic [255:0] req_rdata_b;
    logic [31:0]  pmem_address_b;
    logic         pmem_read_b, pmem_write_b;
    logic [31:0]  pmem_wdata_b;
    logic [31:0]  prdata_b = 32'd0;
    logic         presp_b  = 1'b0;

    pmem_arbiter #(
        .NUM_PORTS  (3),
        .ADDR_WIDTH (32),
        .BEAT_WIDTH (32),
        .BURST_LEN  (8)
    ) dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_read_i     (req_read_b),
        .req_write_i    (req_write_b),
        .req_addr_i     (req_addr_b),
        .req_wdata_i    (req_wdata_b),
        .req_resp_o     (req_resp_b),
        .req_rdata_o    (req_rdata_b),
        .pmem_address_o (pmem_address_b),
        .pmem_read_o    (pmem_read_b),
        .pmem_write_o   (pmem_write_b),
        .pmem_wdata_o   (pmem_wdata_b),
        .pmem_rdata_i   (prdata_b),
        .pmem_resp_i    (presp_b)
    );

    // ---------------- memory model A ----------------
    logic [255:0] mline_a = 256'd0;
    int           stall_a = 0;
    logic [255:0] wcap_a  = 256'd0;
    logic [31:0]  acap_a  = 32'd0;
    logic         kind_a  = 1'b0;
    int           wait_a  = 0;
    int           idx_a   = 0;
    int           beats_a = 0;

    always @(negedge clk) begin
        if (pmem_read_a || pmem_write_a) begin
            if (wait_a > 0) begin
                presp_a = 1'b0;
                wait_a  = wait_a - 1;
            end else begin
                presp_a  = 1'b1;
                prdata_a = mline_a[idx_a*64 +: 64];
                if (pmem_write_a) wcap_a[idx_a*64 +: 64] = pmem_wdata_a;
                if (idx_a == 0) begin
                    acap_a = pmem_address_a;
                    kind_a = pmem_write_a;
                end
                idx_a   = (idx_a + 1) % 4;
                beats_a = beats_a + 1;
                wait_a  = stall_a;
            end
        end else begin
            presp_a = 1'b0;
            idx_a   = 0;
            wait_a  = stall_a;
        end
    end

    // ---------------- memory model B (no stalls) ----------------
    logic [255:0] mline_b = 256'd0;
    logic [255:0] wcap_b  = 256'd0;
    logic [31:0]  acap_b  = 32'd0;
    int           idx_b   = 0;
    int           beats_b = 0;

    always @(negedge clk) begin
        if (pmem_read_b || pmem_write_b) begin
            presp_b  = 1'b1;
            prdata_b = mline_b[idx_b*32 +: 32];
            if (pmem_write_b) wcap_b[idx_b*32 +: 32] = pmem_wdata_b;
            if (idx_b == 0) acap_b = pmem_address_b;
            idx_b   = (idx_b + 1) % 8;
            beats_b = beats_b + 1;
        end else begin
            presp_b = 1'b0;
            idx_b   = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction on instance A; latency counts the request cycle as 1.
    task automatic txn_a(input int port, input bit wr, input logic [31:0] addr,
                         input logic [255:0] line, output logic [1:0] resp,
                         output logic [255:0] rdata, output int lat, output bit twice);
        @(negedge clk);
        req_addr_a[port*32 +: 32]   = addr;
        req_wdata_a[port*256 +: 256] = line;
        if (wr) req_write_a[port] = 1'b1;
        else    req_read_a[port]  = 1'b1;
        lat   = 1;
        resp  = 2'b00;
        rdata = 256'd0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (|req_resp_a) begin
                resp  = req_resp_a;
                rdata = req_rdata_a;
                break;
            end
        end
        @(negedge clk);
        req_read_a  = 2'b00;
        req_write_a = 2'b00;
        @(posedge clk); #1;
        twice = |req_resp_a;
    endtask

    task automatic txn_b(input int port, input bit wr, input logic [31:0] addr,
                         input logic [255:0] line, output logic [2:0] resp,
                         output logic [255:0] rdata, output int lat);
        @(negedge clk);
        req_addr_b[port*32 +: 32]    = addr;
        req_wdata_b[port*256 +: 256] = line;
        if (wr) req_write_b[port] = 1'b1;
        else    req_read_b[port]  = 1'b1;
        lat   = 1;
        resp  = 3'b000;
        rdata = 256'd0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (|req_resp_b) begin
                resp  = req_resp_b;
                rdata = req_rdata_b;
                break;
            end
        end
        @(negedge clk);
        req_read_b  = 3'b000;
        req_write_b = 3'b000;
    endtask

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [255:0] line;
        logic [31:0] exp_addr;
        int          stall;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [1:0]   resp2;
        logic [2:0]   resp3;
        logic [255:0] rdata;
        int           lat;
        bit           twice;
        int           b0;
        int           exp_g[4];
        int           got;
        int           cnt;

        rst_n       = 1'b0;
        req_read_a  = 2'b00;
        req_write_a = 2'b00;
        req_addr_a  = 64'd0;
        req_wdata_a = 512'd0;
        req_read_b  = 3'b000;
        req_write_b = 3'b000;
        req_addr_b  = 96'd0;
        req_wdata_b = 768'd0;

        vecs[0] = '{0, 1'b0, 32'h0000_1234,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    32'h0000_1220, 0, 6};
        vecs[1] = '{1, 1'b1, 32'h0000_ABCD,
                    {128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA,
                     128'h5555_5555_5555_5555_5555_5555_5555_5555},
                    32'h0000_ABC0, 0, 6};
        vecs[2] = '{1, 1'b0, 32'hFFFF_FFFF,
                    {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                     64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000},
                    32'hFFFF_FFE0, 3, 18};
        vecs[3] = '{0, 1'b1, 32'h0000_0020,
                    {64'h0F0E_0D0C_0B0A_0908, 64'h0706_0504_0302_0100,
                     64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                    32'h0000_0020, 1, 10};
        vecs[4] = '{0, 1'b0, 32'h0000_001F,
                    {64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h1},
                    32'h0000_0000, 0, 6};

        // Reset state.
        @(posedge clk); #1;
        check("rst_pmem_read",  {255'd0, pmem_read_a},  256'd0);
        check("rst_pmem_write", {255'd0, pmem_write_a}, 256'd0);
        check("rst_req_resp",   {254'd0, req_resp_a},   256'd0);
        check("rst_address",    {224'd0, pmem_address_a}, 256'd0);
        check("rst_wdata",      {192'd0, pmem_wdata_a}, 256'd0);
        check("rst_rdata",      req_rdata_a,            256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single transactions.
        for (int i = 0; i < 5; i++) begin
            mline_a = vecs[i].line;
            stall_a = vecs[i].stall;
            b0      = beats_a;
            txn_a(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].line,
                  resp2, rdata, lat, twice);
            check($sformatf("v%0d_resp", i), {254'd0, resp2}, 256'd1 << vecs[i].port);
            check($sformatf("v%0d_lat", i), 256'(lat), 256'(vecs[i].exp_lat));
            check($sformatf("v%0d_addr", i), {224'd0, acap_a}, {224'd0, vecs[i].exp_addr});
            check($sformatf("v%0d_beats", i), 256'(beats_a - b0), 256'd4);
            check($sformatf("v%0d_kind", i), {255'd0, kind_a}, {255'd0, vecs[i].wr});
            check($sformatf("v%0d_single_pulse", i), {255'd0, twice}, 256'd0);
            if (vecs[i].wr) check($sformatf("v%0d_wbeats", i), wcap_a, vecs[i].line);
            else            check($sformatf("v%0d_rdata", i), rdata, vecs[i].line);
        end

        // Reset during beat 2 of a read.
        stall_a = 0;
        mline_a = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                   64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
        @(negedge clk);
        req_addr_a[31:0] = 32'h0000_4000;
        req_read_a[0]    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b0;
        req_read_a = 2'b00;
        @(posedge clk); #1;
        check("midrst_pmem_read", {255'd0, pmem_read_a}, 256'd0);
        check("midrst_resp",      {254'd0, req_resp_a},  256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (|req_resp_a) cnt++;
        end
        check("midrst_no_resp_after", 256'(cnt), 256'd0);
        txn_a(0, 1'b0, 32'h0000_4000, 256'd0, resp2, rdata, lat, twice);
        check("midrst_fresh_lat",   256'(lat), 256'd6);
        check("midrst_fresh_rdata", rdata, mline_a);
        check("midrst_fresh_resp",  {254'd0, resp2}, 256'd1);

        // Both ports requesting continuously.
`ifdef PMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        do_reset();
        @(negedge clk);
        req_read_a = 2'b11;
        for (int g = 0; g < 4; g++) begin
            got = 9;
            for (int c = 0; c < 50; c++) begin
                @(posedge clk); #1;
                if (|req_resp_a) begin
                    got = (req_resp_a == 2'b01) ? 0 : ((req_resp_a == 2'b10) ? 1 : 8);
                    break;
                end
            end
            check($sformatf("arb_grant%0d", g), 256'(got), 256'(exp_g[g]));
            @(negedge clk);
            if (g == 3 || got > 1) begin
                req_read_a = 2'b00;
            end else begin
                req_read_a[got] = 1'b0;
                @(negedge clk);
                req_read_a[got] = 1'b1;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("arb_idle_after", {255'd0, pmem_read_a}, 256'd0);

        // 3-port, 8x32-bit instance: port-2 write then port-1 read.
        b0 = beats_b;
        txn_b(2, 1'b1, 32'h0000_5678,
              256'h8888_8888_7777_7777_6666_6666_5555_5555_4444_4444_3333_3333_2222_2222_1111_1111,
              resp3, rdata, lat);
        check("b_wr_resp",  {253'd0, resp3}, 256'd4);
        check("b_wr_lat",   256'(lat), 256'd10);
        check("b_wr_addr",  {224'd0, acap_b}, 256'h5660);
        check("b_wr_beats", 256'(beats_b - b0), 256'd8);
        check("b_wr_data",  wcap_b,
              256'h8888_8888_7777_7777_6666_6666_5555_5555_4444_4444_3333_3333_2222_2222_1111_1111);
        mline_b = 256'h0706_0504_1716_1514_2726_2524_3736_3534_4746_4544_5756_5554_6766_6564_7776_7574;
        txn_b(1, 1'b0, 32'h0000_0044, 256'd0, resp3, rdata, lat);
        check("b_rd_resp",  {253'd0, resp3}, 256'd2);
        check("b_rd_addr",  {224'd0, acap_b}, 256'h40);
        check("b_rd_data",  rdata,
              256'h0706_0504_1716_1514_2726_2524_3736_3534_4746_4544_5756_5554_6766_6564_7776_7574);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Parametrised burst-memory front end for the mp4 core: arbitrates NUM_PORTS cache-line clients (icache, dcache, optional prefetcher/victim buffer) onto the single physical burst memory port of the `mp4` top. It also serialises and deserialises lines into BURST_LEN beats. It generalises the fixed two-cache, fixed-width pmem hookup to any port count, line width and burst length, and adds fair arbitration.

## Interface
- NUM_PORTS, 2: number of client ports; port 0 is icache by convention.
- ADDR_WIDTH, 32: byte address width.
- BEAT_WIDTH, 64: pmem data beat width in bits.
- BURST_LEN, 4: beats per line; line width LINE_WIDTH = BEAT_WIDTH*BURST_LEN (256 by default).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_read  in  NUM_PORTS  per-port line read request; held until that port's resp.
- req_write  in  NUM_PORTS  per-port line write request; held until that port's resp.
- req_addr  in  NUM_PORTS×ADDR_WIDTH  per-port line address.
- req_wdata  in  NUM_PORTS×LINE_WIDTH  per-port write line.
- req_resp  out  NUM_PORTS  one-cycle completion pulse, at most one bit set.
- req_rdata  out  LINE_WIDTH  assembled read line, valid while any req_resp bit is high.
- pmem_address  out  ADDR_WIDTH  line-aligned burst address.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_wdata  out  BEAT_WIDTH  current write beat.
- pmem_rdata  in  BEAT_WIDTH  read beat, valid with pmem_resp.
- pmem_resp  in  1  beat accepted or delivered.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: pending = req_read|req_write. If any bit is pending, the arbiter picks a grant, latches the granted port index, and zeroes beat_cnt. Next state is WRITE if that port's req_write is set, otherwise READ. If req_read and req_write are both set, write wins; the simulation assertion flags this case.
- READ: pmem_read=1. On each pmem_resp, pmem_rdata is stored into line bits [beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] and beat_cnt increments. On the resp for beat BURST_LEN-1, the state moves to DONE.
- WRITE: pmem_write=1, pmem_wdata = granted line slice [beat_cnt*BEAT_WIDTH +: BEAT_WIDTH]. beat_cnt advances on pmem_resp. The last resp moves the state to DONE.
- DONE: req_resp[grant]=1 for exactly one cycle, with req_rdata = assembled line (reads; don't-care for writes). Then the state returns to IDLE.
- pmem_address = granted req_addr with the low log2(LINE_WIDTH/8) bits zeroed. It is held for the whole burst; client address changes mid-burst are ignored.
- Clients must drop their request the cycle after req_resp. IDLE re-samples requests only one cycle after DONE, so a completed port is never regranted spuriously.
- beat_cnt is $clog2(BURST_LEN) bits wide and wraps to 0 after the final beat. BURST_LEN must be a power of two ≥2, enforced by elaboration check.

## Timing
- Reset (rst=0 at an edge): state=IDLE, beat_cnt=0, grant=0, rr pointer=0, pmem_read=pmem_write=0, req_resp=0, pmem_address=0, pmem_wdata=0, req_rdata=0.
- Reset mid-burst: pmem_read/pmem_write are low in the cycle after the reset edge. The burst is abandoned, with no req_resp, and partial line data is discarded.
- Request high at edge k in IDLE: pmem_read or pmem_write is high from k+1.
- Zero-wait memory: last pmem_resp at edge k+BURST_LEN, then req_resp is high during cycle k+BURST_LEN+1.
- Minimum end-to-end latency is BURST_LEN+2 cycles. Back-to-back grants have one IDLE cycle between them.
- pmem_resp outside READ/WRITE is ignored.
- All outputs are registered or decoded from state and registers only; there is no combinational path from req_* to pmem_*.

## Configuration
- PMEM_ARB_RR_EN defined: round-robin arbitration. Priority starts at the port after the last granted port, and the pointer updates on the IDLE→READ/WRITE transition.
- PMEM_ARB_RR_EN undefined: fixed priority, lowest index wins (icache first). The rr pointer register is not built.

## Structure
- pmem_arb_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - the localparam derivations LINE_WIDTH, BEAT_IDX_W and OFFSET_W;
  - the line-mask helper function.
- Sub-module rr_arbiter: NUM_PORTS-wide request vector to one-hot grant plus index, with update enable. Fixed-priority behaviour is selected inside it by PMEM_ARB_RR_EN.
- The mp4 top instantiates pmem_arbiter between the caches and the pmem_* ports. The testbench keeps connecting the pmem_* ports to the burst memory model.

## Test plan
- Single read, port 0, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. → pmem_address=0x0000_1220, pmem_read high for 4 resp beats, req_resp[0] pulse, req_rdata = {0x44..,0x33..,0x22..,0x11..}.
- Single write, port 1, line 0xAAAA..._5555 → pmem_wdata sequence equals line bits [63:0],[127:64],[191:128],[255:192], and req_resp[1] pulses once.
- Both ports requesting continuously with RR_EN → grants alternate 0,1,0,1. Without RR_EN → port 0 is always granted while its request is held.
- Memory stalls of 3 cycles between beats → pmem_read stays high, beat_cnt holds, and req_rdata is still correct.
- rst=0 during beat 2 of a read → pmem_read low the next cycle, no req_resp, and a fresh request after release gets full latency BURST_LEN+2.
- NUM_PORTS=3, BURST_LEN=8, BEAT_WIDTH=32 → an 8-beat burst completes, and the port-2 write line is serialised correctly.
